rmii_rx: RTL and testbench
==========================

RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 SHALL have port clk, input, 1: 50 MHz LAN8720 reference clock; all logic on its rising edge.
REQ-002 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port rxd, input, 2: RMII receive dibit from the PHY, LSB dibit of each byte first.
REQ-004 SHALL have port crs_dv, input, 1: RMII carrier-sense/data-valid, may toggle at end of frame.
REQ-005 SHALL have port rx_er, input, 1: PHY receive error; present only with RMII_RX_ERR_EN.
REQ-006 SHALL have port received_byte, output, 8: assembled byte; 0xD5 for SFD, then frame bytes.
REQ-007 SHALL have port byte_valid, output, 1: one-cycle pulse qualifying received_byte.
REQ-008 SHALL have port frame_active, output, 1: high from SFD emission until frame_end.
REQ-009 SHALL have port frame_end, output, 1: one-cycle pulse at end of a frame that reached DATA.
REQ-010 SHALL have port align_err, output, 1: valid with frame_end; frame ended on a non-byte boundary.
REQ-011 SHALL have port frame_err, output, 1: valid with frame_end; rx_er was seen during the frame.

Function
REQ-012 SHALL register rxd/crs_dv (and rx_er) into stage 1, then copy stage 1 into stage 2 each cycle; stage 2 dibit is judged using crs_dv of both stage 2 (prev) and stage 1 (cur).
REQ-013 SHALL use the states IDLE, PREAMBLE, DATA, DROP; any other encoding SHALL go to IDLE on the next edge.
REQ-014 IDLE: stage-1 crs_dv high -> PREAMBLE with the preamble counter cleared; no outputs asserted.
REQ-015 PREAMBLE: dibit 00 ignored; dibit 01 increments a saturating 5-bit preamble counter; dibit 10 -> DROP.
REQ-016 PREAMBLE: dibit 11 with count >= 4 -> emit received_byte=0xD5 with byte_valid, set frame_active, clear the dibit index, -> DATA; 11 with count < 4 -> DROP.
REQ-017 PREAMBLE or DROP: crs_dv low on two consecutive samples -> IDLE with no frame_end.
REQ-018 DATA: a stage-2 dibit is accepted if prev or cur crs_dv is high; it is shifted in at bit position 2*idx, and idx increments modulo 4.
REQ-019 DATA: the accept that completes idx=3 SHALL pulse byte_valid on the next edge, with the assembled byte held on received_byte until the next byte.
REQ-020 Latency SHALL be 3 clk edges from sampling the 4th dibit on the pins to byte_valid high.
REQ-021 DATA: prev and cur crs_dv both low -> stage-2 dibit discarded, frame_end pulsed, frame_active cleared, -> IDLE.
REQ-022 align_err SHALL equal (idx != 0) at the end condition; the partial byte SHALL never be emitted.
REQ-023 A single-cycle crs_dv low (toggle) inside DATA SHALL NOT end the frame or drop data.
REQ-024 byte_valid and frame_end SHALL be asserted in the same cycle only if the final byte completes on the last accepted dibit.
REQ-025 Back-to-back frames: a crs_dv rise on the edge after the IDLE return SHALL be captured normally.

Reset
REQ-026 resetn low at a clock edge SHALL set state to IDLE, clear both stages, idx, the counter, and the error flag, and drive received_byte=0x00 and byte_valid, frame_active, frame_end, align_err, frame_err all to 0.
REQ-027 Reset asserted mid-frame SHALL abort silently, with no frame_end and no partial byte emitted.

Configuration
REQ-028 With macro RMII_RX_ERR_EN defined, the rx_er port SHALL exist; rx_er high on any accepted DATA dibit sets a sticky flag that is output as frame_err with frame_end and is cleared on IDLE entry.
REQ-029 Without RMII_RX_ERR_EN, the rx_er port SHALL be absent and frame_err SHALL be tied to 0.

Verification
REQ-030 Preamble of 31x dibit 01, then 11, then byte 0x00 0x1A (dibits 00,00,00,00 / 10,10,01,00), then crs_dv low -> outputs 0xD5, 0x00, 0x1A; frame_end=1, align_err=0.
REQ-031 Same frame with a single-cycle crs_dv low inside the 0x1A byte -> identical output bytes, exactly one frame_end.
REQ-032 Frame ending 2 dibits into a byte -> no partial byte emitted; frame_end=1 with align_err=1.
REQ-033 Preamble of 2x dibit 01, then 11 -> DROP, no byte_valid and no frame_end; a following valid frame is received correctly.
REQ-034 resetn low for 1 cycle mid-DATA -> all outputs 0 on the next edge; no frame_end; the next frame is decoded cleanly.
REQ-035 With RMII_RX_ERR_EN defined, rx_er pulsed 1 cycle mid-DATA -> frame_err=1 with frame_end; the next clean frame gives frame_err=0.

Source files
------------

// File: rtl/rmii_rx.sv
// -----------------------------------------------------------------------------
// rmii_rx
//   RMII receive path for a LAN8720-class PHY. The block double-registers the
//   RMII dibit stream and strips the preamble. After the SFD it assembles
//   bytes, LSB dibit first, and marks the end of each frame.
//
//   Optional feature macro: RMII_RX_ERR_EN
//     defined   : the rx_er port exists. An error seen on any accepted data
//                 dibit is reported as frame_err together with frame_end.
//     undefined : the rx_er port is absent and frame_err is tied low.
//
// Ports
//   clk           in   50 MHz RMII reference clock, rising edge only
//   resetn        in   synchronous active-low reset
//   rxd[1:0]      in   RMII receive dibit
//   crs_dv        in   RMII carrier-sense / data-valid (may toggle at end)
//   rx_er         in   PHY receive error (RMII_RX_ERR_EN only)
//   received_byte out  last assembled byte (0xD5 for the SFD), held
//   byte_valid    out  one-cycle pulse qualifying received_byte
//   frame_active  out  high from SFD emission until frame_end
//   frame_end     out  one-cycle pulse when a frame that reached DATA ends
//   align_err     out  with frame_end: frame ended mid-byte
//   frame_err     out  with frame_end: rx_er was seen during the frame
// -----------------------------------------------------------------------------
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for crs_dv in stage 1
// ST_PREAMBLE | counting 01 dibits, looking for the 11 that closes the SFD
// ST_DATA     | assembling bytes until crs_dv is low in both stages
// ST_DROP     | bad preamble, ignore the rest of the carrier
// -----------------------------------------------------------------------------
module rmii_rx (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] rxd,
  input  logic       crs_dv,
`ifdef RMII_RX_ERR_EN
  input  logic       rx_er,
`endif
  output logic [7:0] received_byte,
  output logic       byte_valid,
  output logic       frame_active,
  output logic       frame_end,
  output logic       align_err,
  output logic       frame_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  localparam logic [4:0] PRE_MAX = 5'd31;
  localparam logic [4:0] PRE_MIN = 5'd4;

  logic [1:0] state;
  logic [1:0] s1_rxd, s2_rxd;
  logic       s1_dv, s2_dv;
  logic [4:0] pre_cnt;
  logic [1:0] idx;
  logic [5:0] shift;   // lower three dibits of the byte being assembled

`ifdef RMII_RX_ERR_EN
  logic       s1_er, s2_er;
  logic       err_flag;
`endif

  // The stage-2 dibit is kept while either its own crs_dv (stage 2) or the
  // following one (stage 1) is high. This rides through the single-cycle
  // crs_dv toggle the PHY produces when carrier drops before the data does.
  logic dibit_live;
  assign dibit_live = s2_dv | s1_dv;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      s1_rxd        <= 2'b00;
      s2_rxd        <= 2'b00;
      s1_dv         <= 1'b0;
      s2_dv         <= 1'b0;
      pre_cnt       <= 5'd0;
      idx           <= 2'd0;
      shift         <= 6'd0;
      received_byte <= 8'h00;
      byte_valid    <= 1'b0;
      frame_active  <= 1'b0;
      frame_end     <= 1'b0;
      align_err     <= 1'b0;
`ifdef RMII_RX_ERR_EN
      s1_er         <= 1'b0;
      s2_er         <= 1'b0;
      err_flag      <= 1'b0;
      frame_err     <= 1'b0;
`endif
    end else begin
      s1_rxd <= rxd;
      s1_dv  <= crs_dv;
      s2_rxd <= s1_rxd;
      s2_dv  <= s1_dv;
`ifdef RMII_RX_ERR_EN
      s1_er     <= rx_er;
      s2_er     <= s1_er;
      frame_err <= 1'b0;
`endif
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;
      align_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (s1_dv) begin
            state   <= ST_PREAMBLE;
            pre_cnt <= 5'd0;
          end
        end

        ST_PREAMBLE: begin
          if (!dibit_live) begin
            state <= ST_IDLE;
`ifdef RMII_RX_ERR_EN
            err_flag <= 1'b0;
`endif
          end else begin
            case (s2_rxd)
              2'b01: begin
                if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 5'd1;
              end
              2'b10: state <= ST_DROP;
              2'b11: begin
                if (pre_cnt >= PRE_MIN) begin
                  received_byte <= 8'hD5;
                  byte_valid    <= 1'b1;
                  frame_active  <= 1'b1;
                  idx           <= 2'd0;
                  state         <= ST_DATA;
                end else begin
                  state <= ST_DROP;
                end
              end
              default: ;
            endcase
          end
        end

        ST_DATA: begin
          if (!dibit_live) begin
            // Any partially assembled byte is dropped here.
            frame_end    <= 1'b1;
            align_err    <= (idx != 2'd0);
            frame_active <= 1'b0;
            state        <= ST_IDLE;
`ifdef RMII_RX_ERR_EN
            frame_err    <= err_flag;
            err_flag     <= 1'b0;
`endif
          end else begin
            case (idx)
              2'd0: shift[1:0] <= s2_rxd;
              2'd1: shift[3:2] <= s2_rxd;
              2'd2: shift[5:4] <= s2_rxd;
              default: begin
                received_byte <= {s2_rxd, shift};
                byte_valid    <= 1'b1;
              end
            endcase
            idx <= idx + 2'd1;
`ifdef RMII_RX_ERR_EN
            if (s2_er) err_flag <= 1'b1;
`endif
          end
        end

        ST_DROP: begin
          if (!dibit_live) begin
            state <= ST_IDLE;
`ifdef RMII_RX_ERR_EN
            err_flag <= 1'b0;
`endif
          end
        end

        default: begin
          state <= ST_IDLE;
`ifdef RMII_RX_ERR_EN
          err_flag <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifndef RMII_RX_ERR_EN
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rmii_rx.sv
module tb_rmii_rx;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] rxd;
  logic       crs_dv;
`ifdef RMII_RX_ERR_EN
  logic       rx_er;
`endif
  logic [7:0] received_byte;
  logic       byte_valid, frame_active, frame_end, align_err, frame_err;

  rmii_rx dut (
    .clk           (clk),
    .resetn        (resetn),
    .rxd           (rxd),
    .crs_dv        (crs_dv),
`ifdef RMII_RX_ERR_EN
    .rx_er         (rx_er),
`endif
    .received_byte (received_byte),
    .byte_valid    (byte_valid),
    .frame_active  (frame_active),
    .frame_end     (frame_end),
    .align_err     (align_err),
    .frame_err     (frame_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [7:0] b; int t; } bexp_t;
  typedef struct { logic al; logic fe; int t; } eexp_t;
  bexp_t sb_b[$];
  eexp_t sb_e[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every output event must match the head of its queue,
  // both in value and in the clk cycle it appears.
  always @(negedge clk) begin : monitor
    bexp_t be;
    eexp_t ee;
    if (byte_valid === 1'b1) begin
      checks++;
      assert (sb_b.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_byte: observed=0x%0h expected=none", received_byte);
      end
      if (sb_b.size() != 0) begin
        be = sb_b.pop_front();
        chk("byte", {24'd0, received_byte}, {24'd0, be.b});
        chk("byte_time", cyc, be.t);
        chk("active_on_byte", {31'd0, frame_active}, 32'd1);
      end
    end
    if (frame_end === 1'b1) begin
      checks++;
      assert (sb_e.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_frame_end: observed=1 expected=0");
      end
      if (sb_e.size() != 0) begin
        ee = sb_e.pop_front();
        chk("align_err", {31'd0, align_err}, {31'd0, ee.al});
        chk("frame_err", {31'd0, frame_err}, {31'd0, ee.fe});
        chk("end_time", cyc, ee.t);
      end
    end
  end

  // Inputs change on the falling edge; the DUT samples them on the next
  // rising edge, so an event caused by this dibit appears three cycles later.
  task automatic drive(input logic [1:0] d, input logic dv, input logic er);
    @(negedge clk);
    rxd    = d;
    crs_dv = dv;
`ifdef RMII_RX_ERR_EN
    rx_er  = er;
`endif
  endtask

  task automatic preamble(input int n);
    bexp_t e;
    repeat (n) drive(2'b01, 1'b1, 1'b0);
    drive(2'b11, 1'b1, 1'b0);
    if (n >= 4) begin
      e.b = 8'hD5; e.t = cyc + 3;
      sb_b.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int toggle_at, input int er_at,
                           input logic push);
    bexp_t e;
    for (int i = 0; i < 4; i++)
      drive(b[2*i +: 2], (i != toggle_at), (i == er_at));
    if (push) begin
      e.b = b; e.t = cyc + 3;
      sb_b.push_back(e);
    end
  endtask

  task automatic end_frame(input logic push, input logic al, input logic fe);
    eexp_t e;
    drive(2'b00, 1'b0, 1'b0);
    if (push) begin
      e.al = al; e.fe = fe; e.t = cyc + 3;
      sb_e.push_back(e);
    end
    drive(2'b00, 1'b0, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) drive(2'b00, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    rxd    = 2'b00;
    crs_dv = 1'b0;
`ifdef RMII_RX_ERR_EN
    rx_er  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_byte",   {24'd0, received_byte}, 32'h00);
    chk("rst_valid",  {31'd0, byte_valid},    32'd0);
    chk("rst_active", {31'd0, frame_active},  32'd0);
    chk("rst_end",    {31'd0, frame_end},     32'd0);
    chk("rst_align",  {31'd0, align_err},     32'd0);
    chk("rst_ferr",   {31'd0, frame_err},     32'd0);
    resetn = 1'b1;
    gap(3);

    // Long saturating preamble, bytes 0x00 0x1A, clean end.
    preamble(31);
    send_byte(8'h00, -1, -1, 1'b1);
    chk("active_mid_frame", {31'd0, frame_active}, 32'd1);
    send_byte(8'h1A, -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);
    gap(4);
    chk("active_after_end", {31'd0, frame_active}, 32'd0);

    // Same frame with a one-cycle crs_dv drop inside 0x1A.
    preamble(31);
    send_byte(8'h00, -1, -1, 1'b1);
    send_byte(8'h1A, 1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);
    gap(4);

    // Frame ending two dibits into a byte.
    preamble(8);
    send_byte(8'h3C, -1, -1, 1'b1);
    drive(2'b11, 1'b1, 1'b0);
    drive(2'b10, 1'b1, 1'b0);
    end_frame(1'b1, 1'b1, 1'b0);
    gap(4);

    // Short preamble: dropped, then a valid frame.
    preamble(2);
    send_byte(8'hAA, -1, -1, 1'b0);
    send_byte(8'h55, -1, -1, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0);
    gap(3);
    preamble(7);
    send_byte(8'hA5, -1, -1, 1'b1);
    send_byte(8'h5A, -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);

    // Back-to-back: carrier rises on the edge after the IDLE return.
    preamble(6);
    send_byte(8'hC3, -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);
    gap(4);

    // Reset pulse mid-DATA: 0x55 is already complete, the next byte is not.
    preamble(5);
    send_byte(8'h55, -1, -1, 1'b1);
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    rxd    = 2'b00;
    crs_dv = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst_byte",   {24'd0, received_byte}, 32'h00);
    chk("mid_rst_valid",  {31'd0, byte_valid},    32'd0);
    chk("mid_rst_active", {31'd0, frame_active},  32'd0);
    chk("mid_rst_end",    {31'd0, frame_end},     32'd0);
    chk("mid_rst_align",  {31'd0, align_err},     32'd0);
    chk("mid_rst_ferr",   {31'd0, frame_err},     32'd0);
    gap(4);
    preamble(9);
    send_byte(8'h81, -1, -1, 1'b1);
    send_byte(8'h7E, -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);
    gap(4);

`ifdef RMII_RX_ERR_EN
    // rx_er on one data dibit flags the frame; the next frame is clean.
    preamble(10);
    send_byte(8'h77, -1, 1, 1'b1);
    send_byte(8'h12, -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b1);
    gap(4);
    preamble(10);
    send_byte(8'h34, -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);
    gap(4);
`endif

    // Pseudo-random payload.
    preamble(12);
    for (int k = 0; k < 6; k++)
      send_byte(8'($urandom_range(0, 255)), -1, -1, 1'b1);
    end_frame(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 50 && (sb_b.size() != 0 || sb_e.size() != 0); i++)
      @(negedge clk);
    chk("sb_bytes_drained", sb_b.size(), 32'd0);
    chk("sb_ends_drained",  sb_e.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
